// File: rtl/wall_map_server_if.sv
// Pixel-request and map-edit signal bundle between the VGA/game side and the
// wall map server.
interface wall_map_server_if;
  logic [5:0] i_request_x;
  logic [5:0] i_request_y;
  logic       i_buzy;
  logic       o_is_wall;
  logic       i_wr_valid;
  logic       o_wr_ready;
  logic [5:0] i_wr_x;
  logic [5:0] i_wr_y;
  logic       i_wr_data;
  logic       i_clear;
  logic       o_clear_busy;

  modport master (
    output i_request_x, i_request_y, i_buzy,
    output i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_clear,
    input  o_is_wall, o_wr_ready, o_clear_busy
  );

  modport slave (
    input  i_request_x, i_request_y, i_buzy,
    input  i_wr_valid, i_wr_x, i_wr_y, i_wr_data, i_clear,
    output o_is_wall, o_wr_ready, o_clear_busy
  );
endinterface

// File: rtl/wall_map_server.sv
// One-bit wall map answering VGA pixel requests with a registered lookup.
// Map edits are queued and committed only while the display side is idle.
module wall_map_server #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned GAME_HEIGHT = 44,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst,
  wall_map_server_if.slave bus
);

  localparam int unsigned CELLS = WIDTH * GAME_HEIGHT;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);

  localparam logic [5:0] X_LAST = 6'(WIDTH - 1);
  localparam logic [5:0] Y_LAST = 6'(GAME_HEIGHT - 1);
  localparam logic [5:0] Y_LIM  = 6'(GAME_HEIGHT);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       data;
  } wr_entry_t;

  function automatic logic [AW-1:0] cell_addr(input logic [5:0] y, input logic [5:0] x);
    return AW'({y, x});
  endfunction

  state_t state, state_next;

  logic [5:0] clr_x, clr_x_next;
  logic [5:0] clr_y, clr_y_next;

  logic          mem [CELLS];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_wdata;
  logic          is_wall;

  wr_entry_t     fifo_q [FIFO_DEPTH];
  wr_entry_t     head_entry;
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic          wr_ready;

  assign fifo_full  = (count == (PW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign head_entry = fifo_q[head];

  assign wr_ready = !fifo_full && (state == IDLE) && !bus.i_clear;
  assign push     = bus.i_wr_valid && wr_ready;

  assign bus.o_wr_ready   = wr_ready;
  assign bus.o_is_wall    = is_wall;
  assign bus.o_clear_busy = (state == CLEAR);

  // Read port: every cycle, never stalled; rows below the play field read as open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wall <= 1'b0;
    end else if (bus.i_request_y < Y_LIM) begin
      is_wall <= mem[cell_addr(bus.i_request_y, bus.i_request_x)];
    end else begin
      is_wall <= 1'b0;
    end
  end

  // Contents are deliberately not reset; the sweep after reset initialises them.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      clr_x <= '0;
      clr_y <= '0;
    end else begin
      state <= state_next;
      clr_x <= clr_x_next;
      clr_y <= clr_y_next;
    end
  end

  always_comb begin
    state_next = state;
    clr_x_next = clr_x;
    clr_y_next = clr_y;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = 1'b0;
    pop        = 1'b0;

    unique case (state)
      CLEAR: begin
        if (bus.i_clear) begin
          clr_x_next = '0;
          clr_y_next = '0;
        end else if (!bus.i_buzy) begin
          mem_we    = 1'b1;
          mem_waddr = cell_addr(clr_y, clr_x);
          mem_wdata = (clr_x == '0) || (clr_x == X_LAST) ||
                      (clr_y == '0) || (clr_y == Y_LAST);
          if (clr_x == X_LAST) begin
            clr_x_next = '0;
            if (clr_y == Y_LAST) begin
              clr_y_next = '0;
              state_next = IDLE;
            end else begin
              clr_y_next = clr_y + 6'd1;
            end
          end else begin
            clr_x_next = clr_x + 6'd1;
          end
        end
      end

      IDLE: begin
        if (bus.i_clear) begin
          state_next = CLEAR;
          clr_x_next = '0;
          clr_y_next = '0;
        end else if (!bus.i_buzy && !fifo_empty) begin
          // Out-of-field entries are still popped so they cannot block the queue.
          pop = 1'b1;
          if (head_entry.y < Y_LIM) begin
            mem_we    = 1'b1;
            mem_waddr = cell_addr(head_entry.y, head_entry.x);
            mem_wdata = head_entry.data;
          end
        end
      end

      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[tail] <= '{x: bus.i_wr_x, y: bus.i_wr_y, data: bus.i_wr_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wall_map_server.sv
// Bench for wall_map_server: read-vector table, hand sequences for the sweep,
// FIFO and reset corners, then random traffic against a cell-array/queue model.
module tb_wall_map_server;

  localparam int W     = 64;
  localparam int H     = 44;
  localparam int CELLS = W * H;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wall_map_server_if bus ();

  wall_map_server #(
    .WIDTH(W),
    .GAME_HEIGHT(H),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int x;
    int y;
    bit d;
  } ent_t;

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic       exp;
  } rd_vec_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: flat cell array with known-flags, sweep position as a cell index, edit queue.
  bit   mm [CELLS];
  bit   mk [CELLS];
  bit   m_sweep;
  int   m_idx;
  ent_t m_q[$];
  bit   m_wall;
  bit   m_wall_k;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit border(input int c);
    int x = c % W;
    int y = c / W;
    return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
  endfunction

  task automatic set_cell(input int c, input bit v);
    mm[c] = v;
    mk[c] = 1'b1;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic cycle();
    bit   exp_ready;
    bit   acc;
    int   a;
    ent_t e;
    #1;
    exp_ready = !m_sweep && (m_q.size() < DEPTH) && !bus.i_clear;
    check("wr_ready", bus.o_wr_ready, exp_ready);
    @(posedge clk);
    acc = bus.i_wr_valid && exp_ready;
    if (int'(bus.i_request_y) < H) begin
      a        = int'(bus.i_request_y) * W + int'(bus.i_request_x);
      m_wall   = mm[a];
      m_wall_k = mk[a];
    end else begin
      m_wall   = 1'b0;
      m_wall_k = 1'b1;
    end
    if (m_sweep) begin
      if (bus.i_clear) begin
        m_idx = 0;
      end else if (!bus.i_buzy) begin
        set_cell(m_idx, border(m_idx));
        m_idx++;
        if (m_idx == CELLS) m_sweep = 1'b0;
      end
    end else if (bus.i_clear) begin
      m_sweep = 1'b1;
      m_idx   = 0;
    end else if (!bus.i_buzy && m_q.size() > 0) begin
      e = m_q.pop_front();
      if (e.y < H) set_cell(e.y * W + e.x, e.d);
    end
    if (acc) m_q.push_back('{x: int'(bus.i_wr_x), y: int'(bus.i_wr_y), d: bus.i_wr_data});
    @(negedge clk);
    if (m_wall_k) check("is_wall", bus.o_is_wall, m_wall);
    check("clear_busy", bus.o_clear_busy, m_sweep);
  endtask

  task automatic idle_inputs();
    bus.i_wr_valid = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_wr_x     = '0;
    bus.i_wr_y     = '0;
    bus.i_wr_data  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_is_wall", bus.o_is_wall, 0);
    check("rst_clear_busy", bus.o_clear_busy, 1);
    check("rst_wr_ready", bus.o_wr_ready, 0);
    m_sweep = 1'b1;
    m_idx   = 0;
    m_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_idle(output int n);
    n = 0;
    while (bus.o_clear_busy && n < 10000) begin
      cycle();
      n++;
    end
  endtask

  task automatic push(input int x, input int y, input bit d);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_x     = 6'(x);
    bus.i_wr_y     = 6'(y);
    bus.i_wr_data  = d;
    cycle();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input int x, input int y, input bit exp);
    bus.i_request_x = 6'(x);
    bus.i_request_y = 6'(y);
    cycle();
    check(name, bus.o_is_wall, exp);
  endtask

  rd_vec_t rv[10];

  initial begin
    int n;
    rv[0] = '{x: 6'd0,  y: 6'd5,  exp: 1'b1};
    rv[1] = '{x: 6'd5,  y: 6'd5,  exp: 1'b0};
    rv[2] = '{x: 6'd63, y: 6'd43, exp: 1'b1};
    rv[3] = '{x: 6'd5,  y: 6'd44, exp: 1'b0};
    rv[4] = '{x: 6'd63, y: 6'd0,  exp: 1'b1};
    rv[5] = '{x: 6'd62, y: 6'd42, exp: 1'b0};
    rv[6] = '{x: 6'd0,  y: 6'd43, exp: 1'b1};
    rv[7] = '{x: 6'd32, y: 6'd0,  exp: 1'b1};
    rv[8] = '{x: 6'd1,  y: 6'd1,  exp: 1'b0};
    rv[9] = '{x: 6'd30, y: 6'd47, exp: 1'b0};

    for (int i = 0; i < CELLS; i++) begin
      mm[i] = 1'b0;
      mk[i] = 1'b0;
    end
    m_wall   = 1'b0;
    m_wall_k = 1'b0;
    idle_inputs();
    bus.i_buzy      = 1'b0;
    bus.i_request_x = '0;
    bus.i_request_y = '0;

    @(negedge clk);
    do_reset();

    run_until_idle(n);
    check("sweep_len", n, CELLS);
    for (int i = 0; i < 10; i++) begin
      read_check("table_read", int'(rv[i].x), int'(rv[i].y), rv[i].exp);
    end

    // Stalled sweep: 1000 busy cycles must push completion out by exactly 1000.
    do_reset();
    for (int i = 0; i < 500; i++) cycle();
    bus.i_buzy = 1'b1;
    for (int i = 0; i < 1000; i++) cycle();
    bus.i_buzy = 1'b0;
    run_until_idle(n);
    check("sweep_stall_len", 500 + 1000 + n, CELLS + 1000);

    // Fill the FIFO while the display is busy, then drain.
    bus.i_buzy      = 1'b1;
    bus.i_request_x = 6'd10;
    bus.i_request_y = 6'd10;
    push(10, 10, 1'b1);
    push(11, 10, 1'b1);
    push(12, 10, 1'b1);
    push(10, 10, 1'b0);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_x     = 6'd13;
    bus.i_wr_y     = 6'd10;
    bus.i_wr_data  = 1'b1;
    #1;
    check("fifo_full_ready", bus.o_wr_ready, 0);
    cycle();
    bus.i_wr_valid = 1'b0;
    read_check("busy_hold_10_10", 10, 10, 1'b0);
    bus.i_buzy = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    read_check("drain_10_10", 10, 10, 1'b0);
    read_check("drain_11_10", 11, 10, 1'b1);
    read_check("drain_12_10", 12, 10, 1'b1);
    read_check("drop_13_10", 13, 10, 1'b0);

    // Out-of-field write is consumed without touching the map.
    push(5, 44, 1'b1);
    cycle();
    read_check("oob_5_44", 5, 44, 1'b0);
    read_check("oob_5_43", 5, 43, 1'b1);

    // Queued edits survive a clear and land on the fresh border pattern.
    bus.i_buzy = 1'b1;
    push(20, 20, 1'b1);
    push(0, 0, 1'b0);
    bus.i_buzy  = 1'b0;
    bus.i_clear = 1'b1;
    #1;
    check("clear_ready", bus.o_wr_ready, 0);
    cycle();
    bus.i_clear = 1'b0;
    run_until_idle(n);
    check("clear_sweep_len", n, CELLS);
    cycle();
    cycle();
    read_check("post_clear_20_20", 20, 20, 1'b1);
    read_check("post_clear_0_0", 0, 0, 1'b0);

    // Reset drops queued edits and restarts a partial sweep.
    bus.i_buzy = 1'b1;
    push(30, 30, 1'b1);
    bus.i_buzy = 1'b0;
    do_reset();
    for (int i = 0; i < 7 * W + 20; i++) cycle();
    do_reset();
    run_until_idle(n);
    check("restart_sweep_len", n, CELLS);
    cycle();
    cycle();
    read_check("lost_30_30", 30, 30, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.i_request_x = 6'($urandom_range(0, 63));
      bus.i_request_y = 6'($urandom_range(0, 47));
      bus.i_buzy      = ($urandom_range(0, 3) == 0);
      bus.i_clear     = ($urandom_range(0, 999) == 0);
      bus.i_wr_valid  = ($urandom_range(0, 1) == 1);
      bus.i_wr_x      = 6'($urandom_range(0, 63));
      bus.i_wr_y      = 6'($urandom_range(0, 47));
      bus.i_wr_data   = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/wall_map_server.md
Name: wall_map_server

Overview:
- Game-side responder to the VGA pixel-request interface.
- Holds the 64x44 one-bit wall map and answers each (request_x, request_y) with a registered wall bit.
- Accepts map edits through a valid/ready write port and buffers them in a small FIFO.
- Commits buffered edits and clear sweeps only while the display side is not busy, so the map is never modified mid-frame.

Parameters:
- WIDTH, 64, grid columns (640 px / 10 px per grid).
- GAME_HEIGHT, 44, playable grid rows (48 rows minus 4-row status bar).
- FIFO_DEPTH, 4, write-buffer entries (power of two).

Ports:
- clk  input  1  system clock, same clock as the VGA block.
- rst  input  1  asynchronous, active-high reset.
- i_request_x  input  6  requested column, driven by the VGA block.
- i_request_y  input  6  requested row, driven by the VGA block.
- i_buzy  input  1  high while VGA is in active vertical display; map writes are forbidden.
- o_is_wall  output  1  wall bit for the request sampled on the previous cycle.
- i_wr_valid  input  1  write request valid.
- o_wr_ready  output  1  write request accepted this cycle.
- i_wr_x  input  6  write column.
- i_wr_y  input  6  write row.
- i_wr_data  input  1  wall value to store.
- i_clear  input  1  one-cycle pulse: re-initialise the map to the border pattern.
- o_clear_busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Storage: WIDTH*GAME_HEIGHT bits, addressed {y,x}. Single port; one access per cycle.
- Read path:
  - Every cycle, o_is_wall <= mem[{i_request_y, i_request_x}].
  - Latency is exactly 1 cycle.
  - If i_request_y >= GAME_HEIGHT, o_is_wall <= 0.
  - Reads always have priority and are never stalled.
- Reset:
  - o_is_wall=0, o_wr_ready=0, o_clear_busy=1.
  - FIFO empty; clear counter x=0, y=0; state=CLEAR.
  - Memory contents are not reset; the automatic clear sweep initialises them.
- FSM states are CLEAR and IDLE.
- CLEAR:
  - Advances one cell per cycle, only on cycles with i_buzy=0; holds when i_buzy=1.
  - Writes mem[{y,x}] = (x==0 || x==WIDTH-1 || y==0 || y==GAME_HEIGHT-1).
  - x increments; it wraps at WIDTH-1 to 0 with y+1.
  - After writing (WIDTH-1, GAME_HEIGHT-1): next state IDLE, o_clear_busy=0 on the following cycle.
  - A full sweep needs 2816 non-busy cycles.
- IDLE:
  - i_clear=1 -> CLEAR with counter reset to 0,0; o_clear_busy=1 the next cycle.
  - Otherwise, if i_buzy=0 and the FIFO is not empty, pop one entry per cycle and write mem[{y,x}]=data.
  - Entries with y >= GAME_HEIGHT are popped and discarded.
- i_clear in CLEAR restarts the sweep at 0,0. i_clear in reset is ignored.
- Write port:
  - o_wr_ready = !fifo_full && state==IDLE && !i_clear (combinational).
  - Push when i_wr_valid && o_wr_ready.
  - Push and pop in the same cycle are both permitted; the count is unchanged.
  - FIFO contents are preserved across a clear sweep and drained, in order, after it. Entries accepted before i_clear therefore land on top of the cleared map.
- Ordering: FIFO is strictly FIFO. Two writes to the same cell resolve to the later one.
- i_buzy going high mid-drain: the pop in that cycle does not occur; remaining entries wait.
- rst asserted mid-sweep or mid-drain: everything returns to the reset values above; FIFO contents are lost.

Test Plan:
- Reset, hold i_buzy=0 -> o_clear_busy=1 for 2816 cycles then 0. Request (0,5) -> o_is_wall=1 one cycle later; (5,5) -> 0; (63,43) -> 1.
- i_buzy held 1 during the sweep for 1000 cycles -> clear counter frozen; completion delayed exactly 1000 cycles.
- IDLE, i_buzy=1, push 4 writes (10,10,1), (11,10,1), (12,10,1), (10,10,0) -> o_wr_ready=0 after the 4th; reads of (10,10) remain 0. Drop i_buzy -> 4 pops in 4 cycles; final (10,10)=0, (11,10)=1, (12,10)=1.
- Write (5,44,1) -> accepted, popped, discarded. Request (5,44) -> o_is_wall=0; (5,43) unchanged (=1).
- IDLE with 2 queued writes, pulse i_clear with i_buzy=0 -> o_wr_ready=0 and a 2816-cycle sweep. Afterwards both writes apply in the next 2 cycles.
- Assert rst mid-sweep at cell (20,7) -> o_is_wall=0, o_clear_busy=1, sweep restarts at (0,0), FIFO empty.
